// File: rtl/multi_channel_clock_divider.sv
// NUM_CH independent integer clock dividers with registered square-wave, tick and running outputs.
// Optional macro CLKDIV_SYNC_EN adds sync_all, which restarts every enabled channel in phase.
module multi_channel_clock_divider #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 24,
  parameter int RESET_DIV = 25000,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              inClock,
  input  logic              reset,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_en,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync_all,
`endif
  output logic [NUM_CH-1:0] outClock,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] running
);

  localparam logic [CNT_W-1:0] RESET_DIV_C = (RESET_DIV < 2) ? CNT_W'(2) : CNT_W'(RESET_DIV);

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    return (d < CNT_W'(2)) ? CNT_W'(2) : d;
  endfunction

  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [CNT_W-1:0]  div_q  [NUM_CH];
  logic [CNT_W-1:0]  div_d  [NUM_CH];
  logic [CNT_W-1:0]  pend_q [NUM_CH];
  logic [CNT_W-1:0]  pend_d [NUM_CH];
  logic [NUM_CH-1:0] pv_q, pv_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] out_q, out_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] wr_hit_s;
  logic [NUM_CH-1:0] last_s;
  logic              sync_s;
  logic              cfg_valid_s;
  logic [CNT_W-1:0]  cfg_div_c_s;

`ifdef CLKDIV_SYNC_EN
  assign sync_s = sync_all;
`else
  assign sync_s = 1'b0;
`endif

  assign cfg_valid_s = cfg_wr && (32'(cfg_ch) < 32'(NUM_CH));
  assign cfg_div_c_s = clamp_div(cfg_div);

  // Per-channel write decode and end-of-period detection
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit_s[i] = cfg_valid_s && (cfg_ch == CH_W'(i));
      last_s[i]   = en_q[i] && (cnt_q[i] == div_q[i] - CNT_W'(1));
    end
  end

  // Next-state counter/divisor logic; outputs are derived from the next state so they register cleanly
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]  = cnt_q[i];
      div_d[i]  = div_q[i];
      pend_d[i] = pend_q[i];
      pv_d[i]   = pv_q[i];
      en_d[i]   = en_q[i];
      if (wr_hit_s[i]) begin
        if (!cfg_en) begin
          en_d[i]  = 1'b0;
          cnt_d[i] = '0;
          div_d[i] = cfg_div_c_s;
          pv_d[i]  = 1'b0;
        end else if (!en_q[i] || last_s[i]) begin
          // Start of a stopped channel, or a write landing exactly on the boundary
          en_d[i]  = 1'b1;
          cnt_d[i] = '0;
          div_d[i] = cfg_div_c_s;
          pv_d[i]  = 1'b0;
        end else begin
          pend_d[i] = cfg_div_c_s;
          pv_d[i]   = 1'b1;
          cnt_d[i]  = cnt_q[i] + CNT_W'(1);
        end
      end else if (en_q[i] && (sync_s || last_s[i])) begin
        cnt_d[i] = '0;
        div_d[i] = pv_q[i] ? pend_q[i] : div_q[i];
        pv_d[i]  = 1'b0;
      end else if (en_q[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else begin
        cnt_d[i] = '0;
      end
      out_d[i]  = en_d[i] && (cnt_d[i] < (div_d[i] >> 1));
      tick_d[i] = en_d[i] && (cnt_d[i] == div_d[i] - CNT_W'(1));
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge inClock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= '0;
        div_q[i]  <= RESET_DIV_C;
        pend_q[i] <= RESET_DIV_C;
      end
      pv_q   <= '0;
      en_q   <= '0;
      out_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        div_q[i]  <= div_d[i];
        pend_q[i] <= pend_d[i];
      end
      pv_q   <= pv_d;
      en_q   <= en_d;
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign outClock = out_q;
  assign tick     = tick_q;
  assign running  = en_q;

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Self-checking bench for multi_channel_clock_divider: period-position reference model plus directed literal checks.
// NUM_CH=3 so that cfg_ch=3 exercises the out-of-range channel path.
module tb_multi_channel_clock_divider;
  localparam int NUM_CH    = 3;
  localparam int CNT_W     = 24;
  localparam int RESET_DIV = 25000;
  localparam int CH_W      = 2;

  logic              inClock = 1'b0;
  logic              reset;
  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_en;
`ifdef CLKDIV_SYNC_EN
  logic              sync_all;
`endif
  logic [NUM_CH-1:0] outClock;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] running;

  int checks = 0;
  int errors = 0;

  always #5 inClock = ~inClock;

  multi_channel_clock_divider #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .RESET_DIV(RESET_DIV)
  ) dut (
    .inClock (inClock),
    .reset   (reset),
    .cfg_wr  (cfg_wr),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .cfg_en  (cfg_en),
`ifdef CLKDIV_SYNC_EN
    .sync_all(sync_all),
`endif
    .outClock(outClock),
    .tick    (tick),
    .running (running)
  );

  // Reference model: each enabled channel is described by the cycle its current period began
  int m_en [NUM_CH];
  int m_d  [NUM_CH];
  int m_p  [NUM_CH];
  int m_pv [NUM_CH];
  int m_st [NUM_CH];
  int cyc = 0;
  bit model_valid = 1'b0;
  logic [NUM_CH-1:0] exp_out, exp_tick, exp_run;

  function automatic int clampi(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  always @(posedge inClock) begin
    bit sy, wr, bnd;
    int pos;
`ifdef CLKDIV_SYNC_EN
    sy = sync_all;
`else
    sy = 1'b0;
`endif
    cyc = cyc + 1;
    for (int i = 0; i < NUM_CH; i++) begin
      bnd = (m_en[i] != 0) && ((cyc - 1 - m_st[i]) == m_d[i] - 1);
      wr  = cfg_wr && (int'(cfg_ch) == i);
      if (reset) begin
        m_en[i] = 0; m_d[i] = RESET_DIV; m_pv[i] = 0; m_st[i] = cyc;
      end else if (wr && !cfg_en) begin
        m_en[i] = 0; m_d[i] = clampi(int'(cfg_div)); m_pv[i] = 0; m_st[i] = cyc;
      end else if (wr && (m_en[i] == 0 || bnd)) begin
        m_en[i] = 1; m_d[i] = clampi(int'(cfg_div)); m_pv[i] = 0; m_st[i] = cyc;
      end else if (wr) begin
        m_p[i] = clampi(int'(cfg_div)); m_pv[i] = 1;
      end else if ((m_en[i] != 0) && (sy || bnd)) begin
        m_st[i] = cyc;
        if (m_pv[i] != 0) m_d[i] = m_p[i];
        m_pv[i] = 0;
      end
      pos = cyc - m_st[i];
      exp_run[i]  = (m_en[i] != 0);
      exp_out[i]  = (m_en[i] != 0) && (pos < m_d[i] / 2);
      exp_tick[i] = (m_en[i] != 0) && (pos == m_d[i] - 1);
    end
    if (reset) model_valid = 1'b1;
  end

  // Compare DUT outputs against the model mid-cycle
  always @(negedge inClock) begin
    if (model_valid) begin
      checks++;
      if (outClock !== exp_out) begin
        errors++;
        $display("FAIL model outClock cyc=%0d: got %b expected %b", cyc, outClock, exp_out);
      end
      checks++;
      if (tick !== exp_tick) begin
        errors++;
        $display("FAIL model tick cyc=%0d: got %b expected %b", cyc, tick, exp_tick);
      end
      checks++;
      if (running !== exp_run) begin
        errors++;
        $display("FAIL model running cyc=%0d: got %b expected %b", cyc, running, exp_run);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input int ch, input int div, input bit en);
    cfg_wr  = 1'b1;
    cfg_ch  = CH_W'(ch);
    cfg_div = CNT_W'(div);
    cfg_en  = en;
    @(negedge inClock);
    cfg_wr  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_en = 1'b0;
`ifdef CLKDIV_SYNC_EN
    sync_all = 1'b0;
`endif
    repeat (3) @(negedge inClock);
    chk("reset outClock", outClock, 0);
    chk("reset tick", tick, 0);
    chk("reset running", running, 0);
    reset = 1'b0;

    wr(0, 4, 1'b1);
    chk("ch0 start running", running[0], 1);
    for (int k = 0; k < 8; k++) begin
      chk("ch0 D4 out", outClock[0], (k % 4) < 2);
      chk("ch0 D4 tick", tick[0], (k % 4) == 3);
      @(negedge inClock);
    end

    wr(1, 5, 1'b1);
    for (int k = 0; k < 10; k++) begin
      chk("ch1 D5 out", outClock[1], (k % 5) < 2);
      chk("ch1 D5 tick", tick[1], (k % 5) == 4);
      @(negedge inClock);
    end
    wr(1, 0, 1'b0);
    chk("ch1 stop running", running[1], 0);
    chk("ch1 stop out", outClock[1], 0);
    wr(1, 0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      chk("ch1 D0 clamp out", outClock[1], (k % 2) == 0);
      chk("ch1 D0 clamp tick", tick[1], (k % 2) == 1);
      @(negedge inClock);
    end

    // D=10 running: D=6 at cnt=2 then D=8 at cnt=5; only 8 is applied
    wr(0, 10, 1'b0);
    wr(0, 10, 1'b1);
    repeat (2) @(negedge inClock);
    wr(0, 6, 1'b1);
    repeat (2) @(negedge inClock);
    wr(0, 8, 1'b1);
    for (int k = 0; k < 24; k++) begin
      if (k < 4) begin
        chk("ch0 tail out", outClock[0], 0);
        chk("ch0 tail tick", tick[0], k == 3);
      end else begin
        chk("ch0 D8 out", outClock[0], ((k - 4) % 8) < 4);
        chk("ch0 D8 tick", tick[0], ((k - 4) % 8) == 7);
      end
      @(negedge inClock);
    end

    // Write on the tick cycle is applied at that boundary
    wr(0, 10, 1'b0);
    wr(0, 10, 1'b1);
    repeat (9) @(negedge inClock);
    chk("ch0 D10 tick at cnt9", tick[0], 1);
    wr(0, 4, 1'b1);
    for (int k = 0; k < 8; k++) begin
      chk("ch0 bypass out", outClock[0], (k % 4) < 2);
      chk("ch0 bypass tick", tick[0], (k % 4) == 3);
      @(negedge inClock);
    end

    wr(2, 7, 1'b1);
    repeat (3) @(negedge inClock);
    wr(2, 7, 1'b0);
    chk("ch2 stop out", outClock[2], 0);
    chk("ch2 stop tick", tick[2], 0);
    chk("ch2 stop running", running[2], 0);

    wr(3, 5, 1'b0);
    chk("bad ch keeps ch0", running[0], 1);
    chk("bad ch keeps ch1", running[1], 1);

    reset = 1'b1;
    @(negedge inClock);
    chk("mid reset outClock", outClock, 0);
    chk("mid reset tick", tick, 0);
    chk("mid reset running", running, 0);
    reset = 1'b0;

`ifdef CLKDIV_SYNC_EN
    wr(0, 6, 1'b1);
    repeat (2) @(negedge inClock);
    wr(1, 9, 1'b1);
    repeat (3) @(negedge inClock);
    sync_all = 1'b1;
    @(negedge inClock);
    sync_all = 1'b0;
    chk("sync outClock", outClock[1:0], 2'b11);
    for (int k = 0; k < 18; k++) begin
      chk("sync common tick", tick[1:0] == 2'b11, k == 17);
      chk("sync ch0 tick", tick[0], (k % 6) == 5);
      chk("sync ch1 tick", tick[1], (k % 9) == 8);
      @(negedge inClock);
    end
`endif

    for (int n = 0; n < 3000; n++) begin
      cfg_wr  = ($urandom_range(0, 5) == 0);
      cfg_ch  = CH_W'($urandom_range(0, 3));
      cfg_div = CNT_W'($urandom_range(0, 12));
      cfg_en  = ($urandom_range(0, 4) != 0);
      reset   = ($urandom_range(0, 299) == 0);
`ifdef CLKDIV_SYNC_EN
      sync_all = ($urandom_range(0, 39) == 0);
`endif
      @(negedge inClock);
    end
    cfg_wr = 1'b0;
    reset  = 1'b0;
    @(negedge inClock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
